dcm_lock_sequencer: RTL and testbench
=====================================

Name: dcm_lock_sequencer

Overview:
Power-up and lock-recovery controller for a chain of cascaded DCMs, where each DCM's CLKIN comes from the previous DCM's output. It releases the DCM RST inputs one stage at a time and waits for each LOCKED with a timeout. It retries the whole chain on failure and generates the system reset once every stage has been stable for a hold period. It runs on the raw oscillator clock (the IBUFG output, never a DCM output), so it keeps running while DCMs are unlocked.

Parameters:
NUM_DCM, 3, number of cascaded DCM stages; stage 0 is fed by the oscillator.
RST_PULSE, 4, cycles dcm_rst[i] stays asserted per attempt (DCM_SP needs at least 3 CLKIN cycles).
LOCK_TIMEOUT, 65535, cycles allowed from release of a stage until its synced LOCKED is seen; 16-bit counter.
HOLD_CYCLES, 1024, cycles all stages must stay locked before sys_reset deasserts; 24-bit counter.
MAX_RETRIES, 7, timeouts tolerated before entering FAIL; 4-bit counter.

Ports:
clk  in  1  oscillator clock.
reset_n  in  1  asynchronous, active-low reset of all sequencer state.
locked_in  in  NUM_DCM  DCM LOCKED outputs; asynchronous, two-flop synchronised internally to locked_s.
dcm_rst  out  NUM_DCM  active-high RST to each DCM.
sys_reset  out  1  active-high system reset for all DCM clock domains.
all_locked  out  1  high only in RUN.
fail  out  1  sticky lock failure.
retry_count  out  4  number of timeouts since reset_n, saturating at 15.
stage  out  2  index of the stage being sequenced; 0 outside PULSE and WAIT.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=PULSE, stage=0
  - dcm_rst=all ones, sys_reset=1, all_locked=0, fail=0, retry_count=0
  - counters=0, sync flops=0
- Interpret "chain ok(i)" as locked_s[j] high for all j<i.
- PULSE(i):
  - dcm_rst[j]=1 for j>=i; dcm_rst[j]=0 for j<i.
  - Count RST_PULSE cycles, then clear dcm_rst[i], clear the timer and go to WAIT(i).
- WAIT(i):
  - The timer increments every cycle.
  - If locked_s[i] and chain ok(i): go to PULSE(i+1), or to HOLD if i=NUM_DCM-1.
  - If chain ok(i) is false, or the timer reaches LOCK_TIMEOUT: a timeout event occurs.
- Timeout event:
  - retry_count increments, saturating.
  - If the number of timeouts exceeds MAX_RETRIES, go to FAIL.
  - Otherwise set dcm_rst to all ones and go to PULSE(0).
- HOLD:
  - The counter increments while locked_s is all ones.
  - Any zero bit → immediate PULSE(0) with all dcm_rst set. This is not counted as a retry.
  - When the counter reaches HOLD_CYCLES-1, go to RUN on the next edge.
- RUN:
  - sys_reset=0, all_locked=1.
  - Any locked_s bit low → in the same cycle, register sys_reset=1 and all_locked=0 for the next edge, set all dcm_rst, and go to PULSE(0).
  - A loss of lock in RUN does not increment retry_count. This allows unlimited recovery from glitches after a successful lock.
- FAIL:
  - dcm_rst all ones, sys_reset=1, fail=1.
  - Held until reset_n is asserted; locked_in is ignored.
- Outputs:
  - All outputs are registered.
  - sys_reset is 1 in every state except RUN.
- Latency:
  - locked_in rising to the state transition is 3 clk edges: two sync flops plus the FSM.
  - Loss of lock in RUN to sys_reset=1 is 3 edges.
- Simultaneous events in the same cycle: a lock loss in HOLD has priority over hold completion.
- With NUM_DCM=1, stage is still 2 bits wide and only stage 0 is used.
- Timer boundary: with LOCK_TIMEOUT=N, locked_s arriving at timer value N-1 succeeds; arriving at N times out.

Test Plan:
- Lock sequencing: NUM_DCM=3, RST_PULSE=4, HOLD_CYCLES=16. Each locked_in[i] rises 10 cycles after dcm_rst[i] falls.
  - Required: dcm_rst steps 111→110→100→000 in order.
  - sys_reset falls exactly 16 cycles after HOLD is entered; all_locked=1, retry_count=0.
- Timeout and retry: LOCK_TIMEOUT=20, locked_in[1] held low for one attempt.
  - Required: after 20 WAIT(1) cycles, dcm_rst returns to 111 and retry_count=1.
  - The second attempt succeeds and sys_reset later deasserts.
- Failure: MAX_RETRIES=2, locked_in[0] permanently low.
  - Required: after 3 timeouts, fail=1, retry_count=3, dcm_rst=111, sys_reset=1.
  - These hold until reset_n pulses low, after which fail=0.
- Loss of lock in RUN: drop locked_in[2] for 1 cycle.
  - Required: sys_reset=1 within 3 edges and a full resequence from PULSE(0).
  - retry_count is unchanged.
- Upstream drop during WAIT: locked_in[0] falls while in WAIT(2).
  - Required: timeout path taken, retry_count increments, PULSE(0).
- Asynchronous reset mid-HOLD: assert reset_n=0 without a clk edge.
  - Required: dcm_rst=111, sys_reset=1 and all_locked=0 immediately.
  - After release, sequencing restarts from stage 0.

Source files
------------

// File: rtl/dcm_lock_sequencer.sv
// Power-up / lock-recovery sequencer for a cascade of DCMs, clocked from the raw oscillator.
// Releases each DCM reset in turn, waits for lock, retries on timeout and gates the system reset.
module dcm_lock_sequencer #(
    parameter int unsigned NUM_DCM      = 3,
    parameter int unsigned RST_PULSE    = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned HOLD_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_DCM-1:0] locked_in,
    output logic [NUM_DCM-1:0] dcm_rst,
    output logic               sys_reset,
    output logic               all_locked,
    output logic               fail,
    output logic [3:0]         retry_count,
    output logic [1:0]         stage
);

    localparam int unsigned CW = 24;
    localparam int unsigned RW = 4;
    localparam int unsigned SW = 2;

    typedef enum logic [2:0] {
        ST_PULSE = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [NUM_DCM-1:0]   locked_meta_q, locked_s_q;
    logic [NUM_DCM-1:0]   dcm_rst_q, dcm_rst_d;
    logic                 sys_reset_q, all_locked_q, fail_q;
    logic                 chain_ok, lock_cur, all_ok, timeout;

    // Two-flop synchroniser for the asynchronous LOCKED inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta_q <= '0;
            locked_s_q    <= '0;
        end else begin
            locked_meta_q <= locked_in;
            locked_s_q    <= locked_meta_q;
        end
    end

    // Upstream chain health and lock of the stage currently being sequenced
    always_comb begin
        chain_ok = 1'b1;
        lock_cur = 1'b0;
        for (int j = 0; j < int'(NUM_DCM); j++) begin
            if (j < int'(stage_q) && !locked_s_q[j]) chain_ok = 1'b0;
            if (j == int'(stage_q)) lock_cur = locked_s_q[j];
        end
        all_ok = &locked_s_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PULSE;
            stage_q      <= '0;
            cnt_q        <= '0;
            retry_q      <= '0;
            dcm_rst_q    <= '1;
            sys_reset_q  <= 1'b1;
            all_locked_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            dcm_rst_q    <= dcm_rst_d;
            sys_reset_q  <= (state_d != ST_RUN);
            all_locked_q <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        timeout = 1'b0;

        case (state_q)
            ST_PULSE: begin
                if (cnt_q == CW'(RST_PULSE - 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (!chain_ok) begin
                    timeout = 1'b1;
                end else if (lock_cur) begin
                    cnt_d = '0;
                    if (32'(stage_q) == NUM_DCM - 1) begin
                        state_d = ST_HOLD;
                        stage_d = '0;
                    end else begin
                        state_d = ST_PULSE;
                        stage_d = stage_q + SW'(1);
                    end
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                // Lock loss wins over hold completion
                if (!all_ok) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!all_ok) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PULSE;
                stage_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Retry accounting: pre-increment count reaching the limit means this timeout exceeds it
        if (timeout) begin
            retry_d = (retry_q == '1) ? retry_q : retry_q + RW'(1);
            cnt_d   = '0;
            stage_d = '0;
            state_d = (32'(retry_q) >= MAX_RETRIES) ? ST_FAIL : ST_PULSE;
        end
    end

    // Reset pattern follows the state being entered so every output stays registered
    always_comb begin
        dcm_rst_d = '1;
        for (int j = 0; j < int'(NUM_DCM); j++) begin
            case (state_d)
                ST_PULSE: dcm_rst_d[j] = (j >= int'(stage_d));
                ST_WAIT:  dcm_rst_d[j] = (j > int'(stage_d));
                ST_HOLD,
                ST_RUN:   dcm_rst_d[j] = 1'b0;
                default:  dcm_rst_d[j] = 1'b1;
            endcase
        end
    end

    assign dcm_rst     = dcm_rst_q;
    assign sys_reset   = sys_reset_q;
    assign all_locked  = all_locked_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign stage       = stage_q;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Bench for dcm_lock_sequencer: emulated DCMs driven from a reference model, every cycle compared.
module tb_dcm_lock_sequencer;

    localparam int N  = 3;
    localparam int RP = 4;
    localparam int LT = 20;
    localparam int HC = 16;
    localparam int MR = 2;
    localparam int VW = N + 9;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] locked_in;
    logic [N-1:0] dcm_rst;
    logic         sys_reset;
    logic         all_locked;
    logic         fail;
    logic [3:0]   retry_count;
    logic [1:0]   stage;

    dcm_lock_sequencer #(
        .NUM_DCM(N), .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .HOLD_CYCLES(HC), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .locked_in(locked_in), .dcm_rst(dcm_rst),
        .sys_reset(sys_reset), .all_locked(all_locked), .fail(fail),
        .retry_count(retry_count), .stage(stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {P_PULSE, P_WAIT, P_HOLD, P_RUN, P_FAIL} phase_t;

    phase_t       m_phase;
    int           m_stage, m_elapsed, m_timeouts;
    logic [N-1:0] m_s1, m_s2;
    int           vectors, miscompares, cyc;
    int           dly [N];
    int           cnt [N];
    logic [N-1:0] lk, block, force_low;
    bit           rand_in;

    function automatic logic [N-1:0] exp_rst();
        int full;
        full = (1 << N) - 1;
        case (m_phase)
            P_PULSE: return N'(full & ~((1 << m_stage) - 1));
            P_WAIT:  return N'(full & ~((1 << (m_stage + 1)) - 1));
            P_HOLD, P_RUN: return '0;
            default: return '1;
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int r, s;
        r = (m_timeouts > 15) ? 15 : m_timeouts;
        s = (m_phase == P_PULSE || m_phase == P_WAIT) ? m_stage : 0;
        return {exp_rst(), m_phase != P_RUN, m_phase == P_RUN, m_phase == P_FAIL, 4'(r), 2'(s)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {dcm_rst, sys_reset, all_locked, fail, retry_count, stage};
    endfunction

    function automatic void model_reset();
        m_phase = P_PULSE; m_stage = 0; m_elapsed = 0; m_timeouts = 0;
        m_s1 = '0; m_s2 = '0;
    endfunction

    function automatic void restart();
        m_phase = P_PULSE; m_stage = 0; m_elapsed = 0;
    endfunction

    // One clock edge of the sequencer as described in plain terms
    function automatic void model_step();
        logic [N-1:0] ls;
        int below;
        bit chain_ok, all_ok, to;
        ls       = m_s2;
        below    = (1 << m_stage) - 1;
        chain_ok = ((int'(ls) & below) == below);
        all_ok   = (ls == {N{1'b1}});
        to       = 1'b0;
        case (m_phase)
            P_PULSE: begin
                m_elapsed++;
                if (m_elapsed == RP) begin m_phase = P_WAIT; m_elapsed = 0; end
            end
            P_WAIT: begin
                if (!chain_ok) to = 1'b1;
                else if (ls[m_stage]) begin
                    m_elapsed = 0;
                    if (m_stage == N - 1) begin m_phase = P_HOLD; m_stage = 0; end
                    else begin m_phase = P_PULSE; m_stage++; end
                end else begin
                    m_elapsed++;
                    if (m_elapsed == LT) to = 1'b1;
                end
            end
            P_HOLD: begin
                if (!all_ok) restart();
                else begin
                    m_elapsed++;
                    if (m_elapsed == HC) begin m_phase = P_RUN; m_elapsed = 0; end
                end
            end
            P_RUN: if (!all_ok) restart();
            default: ;
        endcase
        if (to) begin
            m_timeouts++;
            if (m_timeouts > MR) begin m_phase = P_FAIL; m_stage = 0; end
            else restart();
        end
        m_s2 = m_s1;
        m_s1 = locked_in;
    endfunction

    // Emulated DCMs lock a fixed delay after their reset is released by the model
    function automatic void update_emu();
        logic [N-1:0] er;
        er = exp_rst();
        for (int i = 0; i < N; i++) begin
            if (er[i]) cnt[i] = 0; else cnt[i]++;
            lk[i] = !er[i] && (cnt[i] > dly[i]) && !block[i];
        end
    endfunction

    task automatic apply_inputs();
        locked_in = rand_in ? N'($urandom) : (lk & ~force_low);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all(tag);
        update_emu();
        apply_inputs();
    endtask

    task automatic do_reset();
        rand_in = 1'b0; force_low = '0;
        reset_n = 1'b0;
        model_reset(); update_emu(); apply_inputs();
        #1;
        check_all("reset");
        chk("reset_vals", 32'(obs_vec()), 32'({3'b111, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0}));
        @(posedge clk); #1;
        check_all("reset_hold");
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic run_until(input phase_t p, input int stg, input int budget, input string tag);
        int k;
        k = 0;
        while (!(m_phase == p && (stg < 0 || m_stage == stg)) && k < budget) begin
            tick(tag);
            k++;
        end
        if (k >= budget) begin
            vectors++; miscompares++;
            $error("FAIL %s: budget of %0d cycles expired waiting for phase %0d", tag, budget, p);
        end
    endtask

    task automatic seq_to_run(input string tag, output logic [4*N-1:0] sig, output int hold_len);
        logic [N-1:0] seq [$];
        int t_hold, t_run;
        seq = {};
        seq.push_back(dcm_rst);
        t_hold = -1; t_run = -1;
        for (int k = 0; k < 600 && t_run < 0; k++) begin
            tick(tag);
            if (dcm_rst != seq[$]) seq.push_back(dcm_rst);
            if (t_hold < 0 && dcm_rst == '0 && stage == 2'd0 && sys_reset) t_hold = cyc;
            if (t_run < 0 && !sys_reset) t_run = cyc;
        end
        sig = (seq.size() == 4) ? {seq[0], seq[1], seq[2], seq[3]} : '0;
        hold_len = t_run - t_hold;
    endtask

    initial begin
        logic [4*N-1:0] sig;
        int hold_len, k;
        vectors = 0; miscompares = 0; cyc = 0;
        reset_n = 1'b1; locked_in = '0; block = '0; force_low = '0; rand_in = 1'b0; lk = '0;
        for (int i = 0; i < N; i++) begin dly[i] = 10; cnt[i] = 0; end
        #2;

        // Power-up sequencing
        do_reset();
        seq_to_run("seq", sig, hold_len);
        chk("rst_order", 32'(sig), 32'({3'b111, 3'b110, 3'b100, 3'b000}));
        chk("hold_len", 32'(hold_len), 32'(16));
        chk("run_flags", 32'({all_locked, retry_count}), 32'({1'b1, 4'd0}));

        // One-cycle loss of lock on the last stage while running
        force_low = 3'b100; apply_inputs();
        k = 0;
        while (!sys_reset && k < 6) begin
            tick("runloss");
            k++;
            if (k == 1) begin force_low = '0; apply_inputs(); end
        end
        chk("runloss_lat", 32'(k), 32'(3));
        run_until(P_RUN, -1, 600, "resequence");
        chk("runloss_retry", 32'({all_locked, retry_count}), 32'({1'b1, 4'd0}));

        // Upstream stage drops while the last stage is waiting
        force_low = 3'b100; apply_inputs();
        tick("glitch2");
        force_low = '0; apply_inputs();
        run_until(P_WAIT, 2, 600, "to_wait2");
        force_low = 3'b001; apply_inputs();
        k = 0;
        while (retry_count == 4'd0 && k < 8) begin tick("updrop"); k++; end
        chk("updrop_lat", 32'(k), 32'(3));
        chk("updrop", 32'({dcm_rst, retry_count, stage}), 32'({3'b111, 4'd1, 2'd0}));
        force_low = '0; apply_inputs();
        run_until(P_RUN, -1, 600, "updrop_recover");
        chk("updrop_run", 32'({sys_reset, retry_count}), 32'({1'b0, 4'd1}));

        // Stage 1 fails to lock on the first attempt only
        block = 3'b010;
        do_reset();
        k = 0;
        for (int c = 0; c < 200 && retry_count == 4'd0; c++) begin
            tick("timeout");
            if (retry_count == 4'd0 && dcm_rst == 3'b100) k++;
        end
        chk("wait1_len", 32'(k), 32'(20));
        chk("timeout_state", 32'({dcm_rst, retry_count}), 32'({3'b111, 4'd1}));
        block = '0;
        run_until(P_RUN, -1, 600, "retry_ok");
        chk("retry_run", 32'({sys_reset, all_locked, retry_count}), 32'({1'b0, 1'b1, 4'd1}));

        // Asynchronous reset in the middle of the hold period
        do_reset();
        run_until(P_HOLD, -1, 600, "to_hold");
        for (int c = 0; c < 5; c++) tick("hold");
        #3;
        reset_n = 1'b0;
        model_reset(); update_emu(); apply_inputs();
        #1;
        chk("async_rst", 32'({dcm_rst, sys_reset, all_locked}), 32'({3'b111, 1'b1, 1'b0}));
        check_all("async_rst_all");
        @(posedge clk); #1;
        check_all("async_rst_hold");
        reset_n = 1'b1;
        seq_to_run("after_async", sig, hold_len);
        chk("async_order", 32'(sig), 32'({3'b111, 3'b110, 3'b100, 3'b000}));

        // Stage 0 never locks: exhaust retries
        block = 3'b001;
        do_reset();
        for (int c = 0; c < 300 && !fail; c++) tick("to_fail");
        chk("fail_state", 32'(obs_vec()), 32'({3'b111, 1'b1, 1'b0, 1'b1, 4'd3, 2'd0}));
        rand_in = 1'b1;
        for (int c = 0; c < 40; c++) tick("fail_hold");
        chk("fail_sticky", 32'(obs_vec()), 32'({3'b111, 1'b1, 1'b0, 1'b1, 4'd3, 2'd0}));
        block = '0;
        do_reset();
        chk("fail_clear", 32'(fail), 32'(0));

        // Randomised lock delays and single-cycle glitches
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 22));
            do_reset();
            for (int c = 0; c < 300; c++) begin
                force_low = ($urandom_range(0, 47) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
                apply_inputs();
                tick("random");
            end
            force_low = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
